// File: rtl/video_pkg.sv
// Shared definitions for the video stream blocks: bus width, arbiter
// state encoding and a helper that sizes counters from image geometry.
package video_pkg;

    localparam int AXIS_DW         = 32;
    localparam int DEF_IMAGE_WIDTH = 640;
    localparam int DEF_IMAGE_HEIGH = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        STREAM = 2'd2
    } arb_state_t;

    // Width of a counter that must hold values 0..depth-1 (at least 1 bit).
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first requester at or
// after ptr, wrapping around NUM_SRC, plus a flag saying one was found.
module rr_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int GW      = 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [GW-1:0]      ptr,
    output logic [GW-1:0]      gnt_idx,
    output logic               gnt_valid
);

    logic [GW:0]   sum;
    logic [GW-1:0] idx;

    // Scan offsets from the far end so the nearest requester wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            sum = {1'b0, ptr} + (GW+1)'(off);
            if (sum >= (GW+1)'(NUM_SRC)) begin
                sum = sum - (GW+1)'(NUM_SRC);
            end
            idx = sum[GW-1:0];
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/video_frame_arbiter.sv
// Frame-granular AXI4-Stream arbiter: grants one source per frame,
// discards beats until its start-of-frame, forwards the whole frame and
// flags line/frame geometry violations.
// Optional per-source frame and drop statistics: define VIDEO_ARB_STATS_EN.
module video_frame_arbiter
    import video_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int image_width = DEF_IMAGE_WIDTH,
    parameter int image_heigh = DEF_IMAGE_HEIGH
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [NUM_SRC-1:0]           src_en_i,
    input  logic [NUM_SRC-1:0]           s_axis_tvalid,
    output logic [NUM_SRC-1:0]           s_axis_tready,
    input  logic [AXIS_DW*NUM_SRC-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]           s_axis_tlast,
    input  logic [NUM_SRC-1:0]           s_axis_tuser,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [AXIS_DW-1:0]           m_axis_tdata,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser,
    output logic [$clog2(NUM_SRC)-1:0]   grant_o,
    output logic                         busy_o,
    output logic                         frame_err_o
`ifdef VIDEO_ARB_STATS_EN
    ,
    output logic [16*NUM_SRC-1:0]        frame_cnt_o,
    output logic [15:0]                  drop_cnt_o
`endif
);

    localparam int GW     = $clog2(NUM_SRC);
    localparam int PIX_W  = cnt_width(image_width);
    localparam int LINE_W = cnt_width(image_heigh);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(image_width - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(image_heigh - 1);

    logic [1:0]         rst_pipe;
    logic               rst_n;
    arb_state_t         state;
    logic [GW-1:0]      rr_ptr;
    logic [PIX_W-1:0]   pix_cnt;
    logic [LINE_W-1:0]  line_cnt;
    logic [NUM_SRC-1:0] req;
    logic [GW-1:0]      arb_idx;
    logic               arb_valid;
    logic [AXIS_DW-1:0] src_data_arr [NUM_SRC];
    logic [AXIS_DW-1:0] src_data;
    logic               src_valid;
    logic               src_last;
    logic               src_user;
    logic               hs;
    logic               frame_end;
    logic               geo_err;

    // Reset asserts immediately but releases in step with the clock.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_split
        assign src_data_arr[i] = s_axis_tdata[AXIS_DW*i +: AXIS_DW];
    end

    assign req       = src_en_i & s_axis_tvalid;
    assign src_data  = src_data_arr[grant_o];
    assign src_valid = s_axis_tvalid[grant_o];
    assign src_last  = s_axis_tlast[grant_o];
    assign src_user  = s_axis_tuser[grant_o];
    assign hs        = (state == STREAM) && src_valid && m_axis_tready;
    assign frame_end = hs && src_last && (line_cnt == LAST_LINE);
    assign geo_err   = hs && ((src_last && (pix_cnt != LAST_PIX)) ||
                              (!src_last && (pix_cnt == LAST_PIX)) ||
                              (src_user && ((pix_cnt != '0) || (line_cnt != '0))));
    assign busy_o    = (state != IDLE);

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .GW      (GW)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (rr_ptr),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // Route the granted source: flush non-SOF beats in SYNC, pass through in STREAM.
    always_comb begin
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = src_data;
        m_axis_tlast  = src_last;
        m_axis_tuser  = src_user;
        case (state)
            SYNC: begin
                s_axis_tready[grant_o] = !src_user;
            end
            STREAM: begin
                m_axis_tvalid          = src_valid;
                s_axis_tready[grant_o] = m_axis_tready;
            end
            default: begin
            end
        endcase
    end

    // Arbitration FSM with frame geometry tracking and error pulse.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_o     <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= geo_err;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant_o <= arb_idx;
                        state   <= SYNC;
                    end
                end
                SYNC: begin
                    if (src_valid && src_user) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (src_last) begin
                            pix_cnt <= '0;
                            if (line_cnt == LAST_LINE) begin
                                line_cnt <= '0;
                                state    <= IDLE;
                                rr_ptr   <= (grant_o == GW'(NUM_SRC - 1)) ? '0 : grant_o + GW'(1);
                            end else begin
                                line_cnt <= line_cnt + LINE_W'(1);
                            end
                        end else begin
                            pix_cnt <= pix_cnt + PIX_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef VIDEO_ARB_STATS_EN
    logic [15:0] frame_cnt [NUM_SRC];
    logic        drop_beat;

    assign drop_beat = (state == SYNC) && src_valid && !src_user;

    // Saturating completed-frame counters per source and SYNC drop counter.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                frame_cnt[i] <= '0;
            end
            drop_cnt_o <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (frame_end && (grant_o == GW'(i)) && (frame_cnt[i] != 16'hFFFF)) begin
                    frame_cnt[i] <= frame_cnt[i] + 16'd1;
                end
            end
            if (drop_beat && (drop_cnt_o != 16'hFFFF)) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_stats
        assign frame_cnt_o[16*i +: 16] = frame_cnt[i];
    end
`endif

endmodule
